// File: rtl/hs_sync_fifo.sv
// hs_sync_fifo: first-word-fall-through valid/ready FIFO that breaks the ready path.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   m_valid/m_data      upstream beat offered to the FIFO
//   m_ready             FIFO has a free slot (registered state only)
//   s_valid/s_data      head entry presented downstream (registered state only)
//   s_ready             downstream accepts the head entry
//   count               occupancy, 0..DEPTH
//   almost_full         count >= AF_LEVEL, only when HS_FIFO_WATERMARK_EN is defined
//
// Optional feature macro: HS_FIFO_WATERMARK_EN (adds almost_full).
module hs_sync_fifo #(
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   parameter int AF_LEVEL = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     m_valid,
   input  logic [WIDTH-1:0]         m_data,
   output logic                     m_ready,
   output logic                     s_valid,
   output logic [WIDTH-1:0]         s_data,
   input  logic                     s_ready,
`ifdef HS_FIFO_WATERMARK_EN
   output logic                     almost_full,
`endif
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("hs_sync_fifo: DEPTH must be a power of 2, at least 2");
   end
   if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
      $error("hs_sync_fifo: AF_LEVEL must be in 1..DEPTH");
   end

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    count_q, count_d;
   logic             full, empty, push, pop;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty   = wr_ptr_q == rd_ptr_q;
   assign m_ready = !full;
   assign s_valid = !empty;
   assign s_data  = mem_q[rd_ptr_q[AW-1:0]];
   assign count   = count_q;
   assign push    = m_valid && m_ready;
   assign pop     = s_valid && s_ready;

   always_comb begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + PW'(push) - PW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (push) mem_q[wr_ptr_q[AW-1:0]] <= m_data;
      end
   end

`ifdef HS_FIFO_WATERMARK_EN
   localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
   assign almost_full = count_q >= AF_L;
`endif
endmodule

// File: tb/tb_hs_sync_fifo.sv
// tb_hs_sync_fifo: directed-vector and scoreboard bench for hs_sync_fifo.
module tb_hs_sync_fifo;
   logic       clk = 1'b0;
   logic       rst_n, m_valid, m_ready, s_valid, s_ready;
   logic [7:0] m_data, s_data;
   logic [2:0] count;
`ifdef HS_FIFO_WATERMARK_EN
   logic       almost_full;
`endif

   always #5 clk = ~clk;

   hs_sync_fifo #(.WIDTH(8), .DEPTH(4), .AF_LEVEL(3)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .m_valid(m_valid),
      .m_data(m_data),
      .m_ready(m_ready),
      .s_valid(s_valid),
      .s_data(s_data),
      .s_ready(s_ready),
`ifdef HS_FIFO_WATERMARK_EN
      .almost_full(almost_full),
`endif
      .count(count)
   );

   typedef struct {
      logic       mv;
      logic [7:0] md;
      logic       sr;
      logic       mr;
      logic       sv;
      logic [7:0] sd;
      logic [2:0] cnt;
   } vec_t;

   vec_t v[17];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic mr, input logic sv, input logic [7:0] sd, input logic [2:0] cnt);
      chk({tag, ".m_ready"}, 32'(m_ready), 32'(mr));
      chk({tag, ".s_valid"}, 32'(s_valid), 32'(sv));
      chk({tag, ".s_data"}, 32'(s_data), 32'(sd));
      chk({tag, ".count"}, 32'(count), 32'(cnt));
`ifdef HS_FIFO_WATERMARK_EN
      chk({tag, ".almost_full"}, 32'(almost_full), 32'(cnt >= 3'd3));
`endif
   endtask

   initial begin
      logic [7:0] q[$];
      int pushed, popped, cyc;
      logic pu, po;
      // {m_valid, m_data, s_ready, exp m_ready, exp s_valid, exp s_data, exp count}
      v[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
      v[1]  = '{1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
      v[2]  = '{1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd1};
      v[3]  = '{1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd2};
      v[4]  = '{1'b1, 8'hA4, 1'b0, 1'b1, 1'b1, 8'hA1, 3'd3};
      v[5]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd4};
      v[6]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA1, 3'd4};
      v[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA1, 3'd4};
      v[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA2, 3'd3};
      v[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA3, 3'd2};
      v[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA4, 3'd1};
      v[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA1, 3'd0};
      v[12] = '{1'b1, 8'hB0, 1'b1, 1'b1, 1'b0, 8'hA1, 3'd0};
      v[13] = '{1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 8'hB0, 3'd1};
      v[14] = '{1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 8'hB1, 3'd1};
      v[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB2, 3'd1};
      v[16] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'hA4, 3'd0};

      rst_n = 1'b0; m_valid = 1'b0; m_data = 8'h00; s_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1 chk_out("reset", 1'b1, 1'b0, 8'h00, 3'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Fill to full, hold off a 5th beat, drain, then push/pop concurrently.
      for (int i = 0; i < 17; i++) begin
         m_valid = v[i].mv; m_data = v[i].md; s_ready = v[i].sr;
         #1 chk_out($sformatf("vec%0d", i), v[i].mr, v[i].sv, v[i].sd, v[i].cnt);
         @(negedge clk);
      end

      // Streaming at one beat per cycle from empty.
      for (int k = 0; k < 20; k++) begin
         m_valid = 1'b1; m_data = 8'(k); s_ready = 1'b1;
         #1 chk_out($sformatf("stream%0d", k), 1'b1, k > 0, k > 0 ? 8'(k - 1) : 8'hA4, k > 0 ? 3'd1 : 3'd0);
         @(negedge clk);
      end
      m_valid = 1'b0;
      #1 chk_out("stream_tail", 1'b1, 1'b1, 8'h13, 3'd1);
      @(negedge clk);
      s_ready = 1'b0;
      #1 chk("stream_empty.s_valid", 32'(s_valid), 32'd0);
      chk("stream_empty.count", 32'(count), 32'd0);

      // Random traffic against a queue scoreboard.
      pushed = 0; popped = 0; cyc = 0;
      while (popped < 1000 && cyc < 8000) begin
         m_valid = (pushed < 1000) && ($urandom_range(0, 1) == 1);
         m_data  = 8'($urandom);
         s_ready = $urandom_range(0, 1) == 1;
         #1;
         chk("rand.m_ready", 32'(m_ready), 32'(q.size() != 4));
         chk("rand.s_valid", 32'(s_valid), 32'(q.size() != 0));
         chk("rand.count", 32'(count), 32'(q.size()));
         if (q.size() != 0) chk("rand.s_data", 32'(s_data), 32'(q[0]));
`ifdef HS_FIFO_WATERMARK_EN
         chk("rand.almost_full", 32'(almost_full), 32'(q.size() >= 3));
`endif
         pu = m_valid && q.size() != 4;
         po = s_ready && q.size() != 0;
         if (po) begin void'(q.pop_front()); popped++; end
         if (pu) begin q.push_back(m_data); pushed++; end
         cyc++;
         @(negedge clk);
      end
      chk("rand.beats_drained", 32'(popped), 32'd1000);
      m_valid = 1'b0; s_ready = 1'b1;
      while (q.size() != 0) begin void'(q.pop_front()); @(negedge clk); end
      s_ready = 1'b0;

      // Asynchronous reset with three beats held.
      m_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         m_data = 8'hC0 + 8'(k);
         @(negedge clk);
      end
      m_valid = 1'b0;
      #1 chk_out("pre_reset", 1'b1, 1'b1, 8'hC0, 3'd3);
      #1 rst_n = 1'b0;
      #1 chk_out("mid_reset", 1'b1, 1'b0, 8'h00, 3'd0);
      @(negedge clk);
      rst_n = 1'b1; m_valid = 1'b1; m_data = 8'hD5;
      #1 chk_out("post_reset", 1'b1, 1'b0, 8'h00, 3'd0);
      @(negedge clk);
      m_valid = 1'b0; s_ready = 1'b1;
      #1 chk_out("post_reset_push", 1'b1, 1'b1, 8'hD5, 3'd1);
      @(negedge clk);
      s_ready = 1'b0;
      #1 chk_out("post_reset_drain", 1'b1, 1'b0, 8'h00, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
